// File: rtl/alu_ex_stage.sv
// alu_ex_stage: EX stage ALU with operand forwarding; define ALU_EX_STAGE_MUL_EN to add a multi-cycle shift-add MUL.
module alu_ex_stage #(
    parameter int XLEN = 64,
    parameter int RW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [RW-1:0]   rs1,
    input  logic [RW-1:0]   rs2,
    input  logic [RW-1:0]   rd,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic            alu_src,
    input  logic [3:0]      alu_op,
    input  logic            reg_write,
    input  logic            exmem_reg_write,
    input  logic [RW-1:0]   exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [RW-1:0]   memwb_rd,
    input  logic [XLEN-1:0] memwb_data,
    output logic [1:0]      forward_a,
    output logic [1:0]      forward_b,
    output logic            stall,
    output logic            out_valid,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic [RW-1:0]   out_rd,
    output logic            out_reg_write,
    output logic [XLEN-1:0] out_store_data
);
    localparam int SW = $clog2(XLEN);
    logic [XLEN-1:0] op_a, fwd_b, op_b, alu_res, mul_prod;
    logic [SW-1:0]   shamt;
    logic [RW-1:0]   mul_rd;
    logic            mul_accept, mul_busy, mul_done, mul_wr, hold, issue;
    logic            valid_q, valid_d, zero_q, zero_d, wr_q, wr_d;
    logic [XLEN-1:0] result_q, result_d, store_q, store_d;
    logic [RW-1:0]   rd_q, rd_d;
    always_comb begin
        forward_a = (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs1) ? 2'b10 :
                    (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs1) ? 2'b01 : 2'b00;
        forward_b = (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs2) ? 2'b10 :
                    (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs2) ? 2'b01 : 2'b00;
        op_a  = forward_a[1] ? exmem_result : forward_a[0] ? memwb_data : rs1_data;
        fwd_b = forward_b[1] ? exmem_result : forward_b[0] ? memwb_data : rs2_data;
        op_b  = alu_src ? imm : fwd_b;
        shamt = op_b[SW-1:0];
        case (alu_op)
            4'b0000: alu_res = op_a & op_b;
            4'b0001: alu_res = op_a | op_b;
            4'b0010: alu_res = op_a + op_b;
            4'b0110: alu_res = op_a - op_b;
            4'b1100: alu_res = ~(op_a | op_b);
            4'b0011: alu_res = op_a << shamt;
            4'b0100: alu_res = op_a >> shamt;
            4'b0101: alu_res = $signed(op_a) >>> shamt;
            4'b0111: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            default: alu_res = '0;
        endcase
    end
`ifdef ALU_EX_STAGE_MUL_EN
    typedef enum logic {IDLE, MUL_BUSY} state_t;
    state_t          state_q, state_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [RW-1:0]   mrd_q, mrd_d;
    logic            mwr_q, mwr_d;
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        mrd_d      = mrd_q;
        mwr_d      = mwr_q;
        mul_accept = state_q == IDLE && in_valid && alu_op == 4'b1000;
        mul_busy   = state_q == MUL_BUSY;
        mul_done   = mul_busy && cnt_q == '0;
        mul_prod   = acc_q + (mplier_q[0] ? mcand_q : '0);
        if (mul_accept) begin
            state_d  = MUL_BUSY;
            cnt_d    = SW'(XLEN - 1);
            mcand_d  = op_a;
            mplier_d = fwd_b;
            acc_d    = '0;
            mrd_d    = rd;
            mwr_d    = reg_write;
        end else if (mul_busy) begin
            state_d  = mul_done ? IDLE : MUL_BUSY;
            cnt_d    = mul_done ? '0 : cnt_q - 1'b1;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = mul_prod;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            mrd_q    <= '0;
            mwr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            mrd_q    <= mrd_d;
            mwr_q    <= mwr_d;
        end
    end
    assign mul_rd = mrd_q;
    assign mul_wr = mwr_q;
    assign stall  = ~reset & (mul_accept | (mul_busy & cnt_q != '0));
`else
    assign mul_accept = 1'b0;
    assign mul_busy   = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_prod   = '0;
    assign mul_rd     = '0;
    assign mul_wr     = 1'b0;
    assign stall      = 1'b0;
`endif
    // The held MUL sits in ID/EX through its final busy cycle, so it must not issue then either.
    always_comb begin
        hold     = mul_accept | mul_busy;
        issue    = in_valid & ~hold;
        valid_d  = mul_done | issue;
        result_d = mul_done ? mul_prod : issue ? alu_res : '0;
        rd_d     = mul_done ? mul_rd : issue ? rd : '0;
        wr_d     = mul_done ? mul_wr : issue & reg_write;
        store_d  = issue ? fwd_b : '0;
        zero_d   = result_d == '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            rd_q     <= '0;
            wr_q     <= 1'b0;
            store_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            store_q  <= store_d;
        end
    end
    assign out_valid      = valid_q;
    assign out_result     = result_q;
    assign out_zero       = zero_q;
    assign out_rd         = rd_q;
    assign out_reg_write  = wr_q;
    assign out_store_data = store_q;
endmodule

// File: tb/tb_alu_ex_stage.sv
// tb_alu_ex_stage: scoreboard bench for alu_ex_stage; MUL scenarios run when ALU_EX_STAGE_MUL_EN is defined.
module tb_alu_ex_stage;
    logic        clk = 1'b0, reset = 1'b1;
    logic        in_valid = 0, alu_src = 0, reg_write = 0;
    logic [4:0]  rs1 = 0, rs2 = 0, rd = 0, exmem_rd = 0, memwb_rd = 0, out_rd;
    logic [63:0] rs1_data = 0, rs2_data = 0, imm = 0, exmem_result = 0, memwb_data = 0;
    logic [3:0]  alu_op = 0;
    logic        exmem_reg_write = 0, memwb_reg_write = 0;
    logic [1:0]  forward_a, forward_b;
    logic        stall, out_valid, out_zero, out_reg_write;
    logic [63:0] out_result, out_store_data;
    typedef struct {logic [63:0] res; logic [63:0] st; logic [4:0] rd; logic wr;} exp_t;
    exp_t sb[$];
    int checks = 0, failures = 0;
    alu_ex_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .alu_src(alu_src),
        .alu_op(alu_op), .reg_write(reg_write), .exmem_reg_write(exmem_reg_write),
        .exmem_rd(exmem_rd), .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
        .memwb_rd(memwb_rd), .memwb_data(memwb_data), .forward_a(forward_a),
        .forward_b(forward_b), .stall(stall), .out_valid(out_valid), .out_result(out_result),
        .out_zero(out_zero), .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_store_data(out_store_data)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        int sh;
        sh = int'(b[5:0]);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd6:  return a - b;
            4'd12: return ~(a | b);
            4'd3:  return a << sh;
            4'd4:  return a >> sh;
            4'd5:  return 64'($signed(a) >>> sh);
            4'd7:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            default: return 64'd0;
        endcase
    endfunction
    // Drive one instruction without forwarding hazards and queue its expected output.
    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic src, input logic [4:0] d, input logic wr);
        logic [63:0] other;
        other = {$urandom, $urandom};
        in_valid = 1; alu_op = op; alu_src = src; rd = d; reg_write = wr;
        rs1 = 5'd1; rs2 = 5'd2; rs1_data = a;
        rs2_data = src ? other : b;
        imm = src ? b : other;
        sb.push_back('{ref_alu(op, a, b), rs2_data, d, wr});
        step();
    endtask
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) chk("sb_unexpected_valid", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_result", out_result, e.res);
                chk("sb_zero", out_zero, e.res == 0);
                chk("sb_rd", out_rd, e.rd);
                chk("sb_reg_write", out_reg_write, e.wr);
            end
        end
    end
`ifdef ALU_EX_STAGE_MUL_EN
    task automatic run_mul(input logic [63:0] a, input logic [63:0] b, output int cyc, output int early);
        in_valid = 1; alu_op = 4'b1000; alu_src = 0; rd = 5'd9; reg_write = 1;
        rs1 = 5'd1; rs2 = 5'd2; rs1_data = a; rs2_data = b;
        sb.push_back('{a * b, 64'd0, 5'd9, 1'b1});
        #1;
        cyc = 0; early = 0;
        while (stall && cyc < 200) begin
            cyc++;
            step();
            if (out_valid) early++;
        end
        step();
        in_valid = 0;
        #1;
    endtask
`endif
    initial begin
        int cyc, early;
        logic [3:0] ops[12] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd12, 4'd3, 4'd4, 4'd5, 4'd7, 4'd9, 4'd13, 4'd15};
        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_result", out_result, 0);
        chk("reset_stall", stall, 0);
        step();
        reset = 0;
        step();
        // Both EX/MEM and MEM/WB match rs1: EX/MEM wins.
        in_valid = 1; alu_op = 4'd2; alu_src = 0; rd = 5'd3; reg_write = 1;
        rs1 = 5'd5; rs2 = 5'd6; rs1_data = 64'd1000; rs2_data = 64'd3;
        exmem_reg_write = 1; exmem_rd = 5'd5; exmem_result = 64'd10;
        memwb_reg_write = 1; memwb_rd = 5'd5; memwb_data = 64'd20;
        #1;
        chk("fwd_a_exmem", forward_a, 2'b10);
        chk("fwd_b_none", forward_b, 2'b00);
        sb.push_back('{64'd13, 64'd3, 5'd3, 1'b1});
        step();
        chk("store_data", out_store_data, 64'd3);
        // Register 0 is never forwarded.
        rs1 = 5'd0; exmem_rd = 5'd0; exmem_result = 64'd99; memwb_reg_write = 0;
        rs1_data = 64'd0; alu_src = 1; imm = 64'd7;
        #1;
        chk("fwd_a_x0", forward_a, 2'b00);
        sb.push_back('{64'd7, 64'd3, 5'd3, 1'b1});
        step();
        // MEM/WB-only forwarding on rs2.
        rs1 = 5'd1; rs2 = 5'd4; rs1_data = 64'd100; rs2_data = 64'd555; alu_src = 0; alu_op = 4'd6;
        exmem_reg_write = 1; exmem_rd = 5'd7; memwb_reg_write = 1; memwb_rd = 5'd4; memwb_data = 64'd40;
        #1;
        chk("fwd_b_memwb", forward_b, 2'b01);
        chk("fwd_a_none", forward_a, 2'b00);
        sb.push_back('{64'd60, 64'd40, 5'd3, 1'b1});
        step();
        exmem_reg_write = 0; memwb_reg_write = 0;
        issue(4'd6, 64'd5, 64'd5, 0, 5'd4, 1);
        issue(4'd5, 64'h8000000000000000, 64'd4, 1, 5'd5, 1);
        chk("sra_model", ref_alu(4'd5, 64'h8000000000000000, 64'd4), 64'hF800000000000000);
        issue(4'd7, 64'hFFFFFFFFFFFFFFFF, 64'd1, 0, 5'd6, 0);
        chk("slt_model", ref_alu(4'd7, 64'hFFFFFFFFFFFFFFFF, 64'd1), 64'd1);
        issue(4'd2, 64'hFFFFFFFFFFFFFFFF, 64'd2, 0, 5'd7, 1);
        issue(4'd3, 64'd1, 64'd63, 1, 5'd8, 1);
        in_valid = 0; reg_write = 1; rd = 5'd12;
        step();
        chk("bubble_valid", out_valid, 0);
        chk("bubble_rd", out_rd, 0);
        chk("bubble_reg_write", out_reg_write, 0);
        chk("bubble_result", out_result, 0);
        for (int i = 0; i < 40; i++)
            issue(ops[$urandom_range(0, 11)], {$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        in_valid = 0;
        step();
`ifdef ALU_EX_STAGE_MUL_EN
        run_mul(64'd7, 64'd6, cyc, early);
        chk("mul_stall_cycles", cyc, 64);
        chk("mul_bubbles", early, 0);
        chk("mul_out_valid", out_valid, 1);
        chk("mul_out_result", out_result, 64'd42);
        chk("mul_no_reaccept", stall, 0);
        run_mul({$urandom, $urandom}, {$urandom, $urandom}, cyc, early);
        chk("mul2_stall_cycles", cyc, 64);
        step();
        in_valid = 1; alu_op = 4'b1000; rs1_data = 64'd3; rs2_data = 64'd4; alu_src = 0;
        for (int i = 0; i < 10; i++) step();
        reset = 1;
        #1;
        chk("abort_stall", stall, 0);
        chk("abort_valid", out_valid, 0);
        in_valid = 0;
        step();
        reset = 0;
        step();
        issue(4'd2, 64'd1, 64'd2, 0, 5'd3, 1);
        in_valid = 0;
        step();
        chk("after_abort_result", out_result, 64'd3);
        for (int i = 0; i < 70; i++) step();
`else
        in_valid = 1; alu_op = 4'b1000; alu_src = 0; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
        reg_write = 1; rs1_data = 64'd7; rs2_data = 64'd6;
        #1;
        chk("nomul_stall", stall, 0);
        sb.push_back('{64'd0, 64'd6, 5'd3, 1'b1});
        step();
        in_valid = 0;
        chk("nomul_result", out_result, 0);
        chk("nomul_zero", out_zero, 1);
        chk("nomul_stall_after", stall, 0);
`endif
        for (int i = 0; i < 3; i++) step();
        chk("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
